// File: rtl/wb_stage_arb_if.sv
// Bus bundle for the writeback arbiter: pipeline slot, long-latency result
// handshake and the registered register-file write port.
interface wb_stage_arb_if #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LQ_DEPTH = 2
);
    localparam int BO_W  = $clog2(XLEN/8);
    localparam int CNT_W = $clog2(LQ_DEPTH+1);

    logic              in_valid;
    logic              flush_i;
    logic [2:0]        in_ctrl;
    logic [2:0]        in_funct3;
    logic [BO_W-1:0]   in_byte_off;
    logic [XLEN-1:0]   in_pc4;
    logic [XLEN-1:0]   in_mem_data;
    logic [XLEN-1:0]   in_alu_data;
    logic [REG_AW-1:0] in_rd;
    logic              lr_valid;
    logic              lr_ready;
    logic [REG_AW-1:0] lr_rd;
    logic [XLEN-1:0]   lr_data;
    logic              op_write;
    logic [REG_AW-1:0] write_addr;
    logic [XLEN-1:0]   write_data;
    logic [1:0]        wr_src;
    logic [CNT_W-1:0]  lq_count;

    modport master (
        output in_valid, flush_i, in_ctrl, in_funct3, in_byte_off, in_pc4,
               in_mem_data, in_alu_data, in_rd, lr_valid, lr_rd, lr_data,
        input  lr_ready, op_write, write_addr, write_data, wr_src, lq_count
    );

    modport slave (
        input  in_valid, flush_i, in_ctrl, in_funct3, in_byte_off, in_pc4,
               in_mem_data, in_alu_data, in_rd, lr_valid, lr_rd, lr_data,
        output lr_ready, op_write, write_addr, write_data, wr_src, lq_count
    );
endinterface

// File: rtl/wb_stage_arb.sv
// RISC-V writeback stage: result select, load extension, and arbitration of the
// single registered RF write port between the pipeline and a long-result FIFO.
module wb_stage_arb #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_arb_if.slave bus
);
    localparam int CNT_W = $clog2(LQ_DEPTH+1);
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    logic [XLEN-1:0]   sh;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   pipe_data;
    logic              pipe_wr;
    logic              lr_accept;
    logic              lr_live;
    logic              pop;
    logic              bypass;
    logic              push;
    logic [CNT_W-1:0]  lq_count_next;

    logic              op_write_reg;
    logic [REG_AW-1:0] write_addr_reg;
    logic [XLEN-1:0]   write_data_reg;
    logic [1:0]        wr_src_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  lq_count_reg;

    logic [REG_AW-1:0] lq_rd_mem   [LQ_DEPTH];
    logic [XLEN-1:0]   lq_data_mem [LQ_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LQ_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Loads arrive as the aligned word; the byte offset selects the lane.
    always_comb begin
        sh = bus.in_mem_data >> {bus.in_byte_off, 3'b000};
        case (bus.in_funct3)
            3'b000:  load_data = XLEN'($signed(sh[7:0]));
            3'b100:  load_data = XLEN'(sh[7:0]);
            3'b001:  load_data = XLEN'($signed(sh[15:0]));
            3'b101:  load_data = XLEN'(sh[15:0]);
            3'b010:  load_data = XLEN'($signed(sh[31:0]));
            3'b110:  load_data = XLEN'(sh[31:0]);
            default: load_data = bus.in_mem_data;
        endcase
    end

    always_comb begin
        case (bus.in_ctrl[2:1])
            2'b00:   pipe_data = bus.in_alu_data;
            2'b01:   pipe_data = load_data;
            default: pipe_data = bus.in_pc4;
        endcase
    end

    assign pipe_wr   = bus.in_valid & ~bus.flush_i & bus.in_ctrl[0] & (bus.in_rd != '0);
    assign lr_accept = bus.lr_valid & bus.lr_ready;
    // rd=0 long results are acknowledged but go nowhere.
    assign lr_live   = lr_accept & (bus.lr_rd != '0);
    assign pop       = ~pipe_wr & (lq_count_reg != '0);
    assign bypass    = ~pipe_wr & (lq_count_reg == '0) & lr_live;
    assign push      = lr_live & ~bypass;
    assign lq_count_next = lq_count_reg + CNT_W'(push) - CNT_W'(pop);

    // Ready looks only at the registered count, so a pop this cycle gives no credit.
    assign bus.lr_ready   = (lq_count_reg < CNT_W'(LQ_DEPTH));
    assign bus.op_write   = op_write_reg;
    assign bus.write_addr = write_addr_reg;
    assign bus.write_data = write_data_reg;
    assign bus.wr_src     = wr_src_reg;
    assign bus.lq_count   = lq_count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_mem[wr_ptr_reg]   <= bus.lr_rd;
            lq_data_mem[wr_ptr_reg] <= bus.lr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write_reg   <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            wr_src_reg     <= 2'b00;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            lq_count_reg   <= '0;
        end else begin
            if (pipe_wr) begin
                op_write_reg   <= 1'b1;
                write_addr_reg <= bus.in_rd;
                write_data_reg <= pipe_data;
                wr_src_reg     <= 2'b01;
            end else if (pop) begin
                op_write_reg   <= 1'b1;
                write_addr_reg <= lq_rd_mem[rd_ptr_reg];
                write_data_reg <= lq_data_mem[rd_ptr_reg];
                wr_src_reg     <= 2'b10;
            end else if (bypass) begin
                op_write_reg   <= 1'b1;
                write_addr_reg <= bus.lr_rd;
                write_data_reg <= bus.lr_data;
                wr_src_reg     <= 2'b11;
            end else begin
                // Address and data hold so the RF port does not toggle when idle.
                op_write_reg   <= 1'b0;
                wr_src_reg     <= 2'b00;
            end
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            lq_count_reg <= lq_count_next;
        end
    end
endmodule

// File: tb/tb_wb_stage_arb.sv
// Directed bench for wb_stage_arb: expected writes go into a scoreboard queue
// when a cycle is driven; a negedge monitor pops and checks them.
module tb_wb_stage_arb;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int LQ_DEPTH = 2;
    localparam logic [31:0] MEM = 32'h80FF7F01;
    localparam logic [31:0] ALU_JUNK = 32'hDEADBEEF;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int          due;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  src;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    wb_stage_arb_if #(.XLEN(XLEN), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) bus ();

    wb_stage_arb #(.XLEN(XLEN), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            $display("txn %-16s we=%0d addr=%0d data=0x%08h src=%0d", mon_e.name,
                     bus.op_write, bus.write_addr, bus.write_data, bus.wr_src);
            chk({mon_e.name, ".we"},  64'(bus.op_write), 64'(mon_e.we));
            chk({mon_e.name, ".src"}, 64'(bus.wr_src),   64'(mon_e.src));
            if (mon_e.we) begin
                chk({mon_e.name, ".addr"}, 64'(bus.write_addr), 64'(mon_e.addr));
                chk({mon_e.name, ".data"}, 64'(bus.write_data), 64'(mon_e.data));
            end
        end
    end

    task automatic set_pipe(input bit v, input bit fl, input logic [2:0] ctrl,
                            input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] pc4);
        bus.in_valid    = v;
        bus.flush_i     = fl;
        bus.in_ctrl     = ctrl;
        bus.in_funct3   = f3;
        bus.in_byte_off = off;
        bus.in_rd       = rd;
        bus.in_alu_data = alu;
        bus.in_mem_data = MEM;
        bus.in_pc4      = pc4;
    endtask

    task automatic set_lr(input bit v, input logic [4:0] rd, input logic [31:0] d);
        bus.lr_valid = v;
        bus.lr_rd    = rd;
        bus.lr_data  = d;
    endtask

    task automatic idle();
        set_pipe(0, 0, 3'b000, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0);
        set_lr(0, 5'd0, 32'h0);
    endtask

    // Queue the expected port state for the edge that ends this cycle, then take it.
    task automatic step(input bit we, input logic [4:0] a, input logic [31:0] d,
                        input logic [1:0] s, input string name);
        exp_t e;
        e.due = cyc + 1; e.we = we; e.addr = a; e.data = d; e.src = s; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    int acc;

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.op_write",   64'(bus.op_write),   64'd0);
        chk("rst.write_addr", 64'(bus.write_addr), 64'd0);
        chk("rst.write_data", 64'(bus.write_data), 64'd0);
        chk("rst.wr_src",     64'(bus.wr_src),     64'd0);
        chk("rst.lq_count",   64'(bus.lq_count),   64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 ALU result
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd5, 32'h12345678, 32'h0);
        step(1, 5'd5, 32'h12345678, 2'b01, "t1_alu");

        // T2 loads and PC+4 against mem=0x80FF7F01
        set_pipe(1, 0, 3'b011, 3'b000, 2'd3, 5'd6,  ALU_JUNK, 32'h0); step(1, 5'd6,  32'hFFFFFF80, 2'b01, "t2_lb_off3");
        set_pipe(1, 0, 3'b011, 3'b100, 2'd3, 5'd7,  ALU_JUNK, 32'h0); step(1, 5'd7,  32'h00000080, 2'b01, "t2_lbu_off3");
        set_pipe(1, 0, 3'b011, 3'b001, 2'd2, 5'd8,  ALU_JUNK, 32'h0); step(1, 5'd8,  32'hFFFF80FF, 2'b01, "t2_lh_off2");
        set_pipe(1, 0, 3'b011, 3'b101, 2'd2, 5'd9,  ALU_JUNK, 32'h0); step(1, 5'd9,  32'h000080FF, 2'b01, "t2_lhu_off2");
        set_pipe(1, 0, 3'b011, 3'b000, 2'd0, 5'd10, ALU_JUNK, 32'h0); step(1, 5'd10, 32'h00000001, 2'b01, "t2_lb_off0");
        set_pipe(1, 0, 3'b011, 3'b010, 2'd0, 5'd11, ALU_JUNK, 32'h0); step(1, 5'd11, 32'h80FF7F01, 2'b01, "t2_lw");
        set_pipe(1, 0, 3'b011, 3'b011, 2'd1, 5'd12, ALU_JUNK, 32'h0); step(1, 5'd12, 32'h80FF7F01, 2'b01, "t2_f3_011");
        set_pipe(1, 0, 3'b101, 3'b000, 2'd0, 5'd13, ALU_JUNK, 32'h1004); step(1, 5'd13, 32'h00001004, 2'b01, "t2_pc4");

        // T3 collision: pipe wins, long result queued then drained
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd3, 32'h33, 32'h0);
        set_lr(1, 5'd7, 32'hAA);
        step(1, 5'd3, 32'h33, 2'b01, "t3_pipe");
        chk("t3.lq_count_1", 64'(bus.lq_count), 64'd1);
        idle();
        step(1, 5'd7, 32'hAA, 2'b10, "t3_drain");
        chk("t3.lq_count_0", 64'(bus.lq_count), 64'd0);

        // T4 backpressure: the third result is held until the queue empties
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'(16 + i), 32'h100 + i, 32'h0);
            set_lr(1, 5'(20 + acc), 32'(acc + 1));
            chk($sformatf("t4.lr_ready_%0d", i), 64'(bus.lr_ready), 64'(i < 2));
            step(1, 5'(16 + i), 32'h100 + i, 2'b01, $sformatf("t4_pipe%0d", i));
            if (i < 2) acc++;
        end
        chk("t4.lq_count_full", 64'(bus.lq_count), 64'd2);
        idle();
        step(1, 5'd20, 32'd1, 2'b10, "t4_q1");
        step(1, 5'd21, 32'd2, 2'b10, "t4_q2");
        set_lr(1, 5'd22, 32'd3);
        step(1, 5'd22, 32'd3, 2'b11, "t4_bypass3");
        chk("t4.lq_count_end", 64'(bus.lq_count), 64'd0);

        // T5 no-write slots
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd0, 32'h55, 32'h0);
        set_lr(0, 5'd0, 32'h0);
        step(0, 5'd0, 32'h0, 2'b00, "t5_rd0");
        set_pipe(1, 1, 3'b001, 3'b000, 2'd0, 5'd4, 32'h44, 32'h0);
        step(0, 5'd0, 32'h0, 2'b00, "t5_flush");
        set_pipe(1, 0, 3'b000, 3'b000, 2'd0, 5'd4, 32'h44, 32'h0);
        step(0, 5'd0, 32'h0, 2'b00, "t5_nowrite");
        idle();
        set_lr(1, 5'd0, 32'h77);
        chk("t5.lr_rd0_ready", 64'(bus.lr_ready), 64'd1);
        step(0, 5'd0, 32'h0, 2'b00, "t5_lr_rd0");
        chk("t5.lr_rd0_count", 64'(bus.lq_count), 64'd0);
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd2, 32'h22, 32'h0);
        set_lr(1, 5'd9, 32'h99);
        step(1, 5'd2, 32'h22, 2'b01, "t5_fill");
        set_pipe(1, 1, 3'b001, 3'b000, 2'd0, 5'd4, 32'h44, 32'h0);
        set_lr(0, 5'd0, 32'h0);
        step(1, 5'd9, 32'h99, 2'b10, "t5_flush_drain");
        chk("t5.lq_count_drained", 64'(bus.lq_count), 64'd0);

        // T6 asynchronous reset with two queued entries
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd14, 32'hE, 32'h0);
        set_lr(1, 5'd23, 32'hA1);
        step(1, 5'd14, 32'hE, 2'b01, "t6_fill1");
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd15, 32'hF, 32'h0);
        set_lr(1, 5'd24, 32'hA2);
        step(1, 5'd15, 32'hF, 2'b01, "t6_fill2");
        chk("t6.lq_count_2", 64'(bus.lq_count), 64'd2);
        idle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.op_write",   64'(bus.op_write),   64'd0);
        chk("t6.write_addr", 64'(bus.write_addr), 64'd0);
        chk("t6.write_data", 64'(bus.write_data), 64'd0);
        chk("t6.wr_src",     64'(bus.wr_src),     64'd0);
        chk("t6.lq_count",   64'(bus.lq_count),   64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.lr_ready", 64'(bus.lr_ready), 64'd1);
        step(0, 5'd0, 32'h0, 2'b00, "t6_no_stale");
        set_pipe(1, 0, 3'b001, 3'b000, 2'd0, 5'd1, 32'hCAFE, 32'h0);
        step(1, 5'd1, 32'hCAFE, 2'b01, "t6_after");
        idle();

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
